// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RV32I width codes, FSM states
// and the small decode helpers used at request acceptance.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } lsu_state_t;

    function automatic logic [3:0] lane_mask(input logic [2:0] f3, input logic [1:0] off);
        case (f3)
            F3_B, F3_BU: lane_mask = 4'b0001 << off;
            F3_H, F3_HU: lane_mask = off[1] ? 4'b1100 : 4'b0011;
            F3_W:        lane_mask = 4'b1111;
            default:     lane_mask = '0;
        endcase
    endfunction

    function automatic logic f3_legal(input logic is_store, input logic [2:0] f3);
        if (is_store)
            f3_legal = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        else
            f3_legal = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
                       (f3 == F3_BU) || (f3 == F3_HU);
    endfunction

    function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] off);
        case (f3)
            F3_H, F3_HU: misaligned = off[0];
            F3_W:        misaligned = (off != 2'b00);
            default:     misaligned = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_ctrl_if.sv
// Core request/response and memory bus of the load/store unit; master is the
// core-plus-memory environment, slave is the LSU itself.
interface lsu_ctrl_if;

    logic        req;
    logic        ready;
    logic        is_store;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        rvalid;
    logic [31:0] rdata;
    logic        err;
    logic [31:0] mem_a;
    logic [31:0] mem_wd;
    logic        mem_we;
    logic [3:0]  mem_wm;
    logic [31:0] mem_rd;

    modport master (
        output req, is_store, funct3, addr, wdata, mem_rd,
        input  ready, rvalid, rdata, err, mem_a, mem_wd, mem_we, mem_wm
    );

    modport slave (
        input  req, is_store, funct3, addr, wdata, mem_rd,
        output ready, rvalid, rdata, err, mem_a, mem_wd, mem_we, mem_wm
    );

endinterface

// File: rtl/lsu_load_align.sv
// Selects the addressed byte/half/word from a memory word and sign- or
// zero-extends it according to the RV32I load width code.
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  off_i,
    input  logic [2:0]  funct3_i,
    output logic [31:0] data_o
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v = '0;
        case (off_i)
            2'd0: byte_v = word_i[7:0];
            2'd1: byte_v = word_i[15:8];
            2'd2: byte_v = word_i[23:16];
            2'd3: byte_v = word_i[31:24];
            default: byte_v = '0;
        endcase
        half_v = off_i[1] ? word_i[31:16] : word_i[15:0];

        case (funct3_i)
            F3_B:    data_o = {{24{byte_v[7]}}, byte_v};
            F3_H:    data_o = {{16{half_v[15]}}, half_v};
            F3_W:    data_o = word_i;
            F3_BU:   data_o = {24'b0, byte_v};
            F3_HU:   data_o = {16'b0, half_v};
            default: data_o = '0;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Single-outstanding load/store initiator: IDLE -> ACCESS -> RESP, with
// faulting requests skipping ACCESS so memory is never touched.
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter bit MISALIGN_TRAP = 1'b1
) (
    input logic       clk,
    input logic       reset_n,
    lsu_ctrl_if.slave lsu
);

    lsu_state_t  state_q, state_d;
    logic        st_q;
    logic [2:0]  f3_q;
    logic [1:0]  off_q;
    logic [3:0]  wm_q;
    logic        err_q;
    logic [31:0] mem_a_q;
    logic [31:0] mem_wd_q;
    logic [31:0] rdata_q;

    logic [1:0]  off_d;
    logic        err_d;
    logic        accept;
    logic [31:0] load_data;

    // Without trapping, offset bits below the access size are simply dropped,
    // which also makes the misalignment check below always pass.
    always_comb begin
        off_d = lsu.addr[1:0];
        if (!MISALIGN_TRAP) begin
            case (lsu.funct3)
                F3_H, F3_HU: off_d = {lsu.addr[1], 1'b0};
                F3_W:        off_d = 2'b00;
                default:     off_d = lsu.addr[1:0];
            endcase
        end
        err_d  = !f3_legal(lsu.is_store, lsu.funct3) || misaligned(lsu.funct3, off_d);
        accept = lsu.req && (state_q == IDLE);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (lsu.req) state_d = err_d ? RESP : ACCESS;
            ACCESS:  state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        lsu.ready  = (state_q == IDLE);
        lsu.rvalid = (state_q == RESP);
        lsu.err    = (state_q == RESP) && err_q;
        lsu.rdata  = (state_q == RESP) ? rdata_q : '0;
        lsu.mem_we = (state_q == ACCESS) && st_q;
        lsu.mem_wm = (state_q == ACCESS) ? wm_q : '0;
        lsu.mem_a  = mem_a_q;
        lsu.mem_wd = mem_wd_q;
    end

    lsu_load_align u_align (
        .word_i   (lsu.mem_rd),
        .off_i    (off_q),
        .funct3_i (f3_q),
        .data_o   (load_data)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            st_q     <= 1'b0;
            f3_q     <= '0;
            off_q    <= '0;
            wm_q     <= '0;
            err_q    <= 1'b0;
            mem_a_q  <= '0;
            mem_wd_q <= '0;
            rdata_q  <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                st_q    <= lsu.is_store;
                f3_q    <= lsu.funct3;
                off_q   <= off_d;
                err_q   <= err_d;
                rdata_q <= '0;
                // Bus registers only move for requests that will reach ACCESS.
                if (!err_d) begin
                    mem_a_q  <= {lsu.addr[31:2], 2'b00};
                    mem_wd_q <= lsu.wdata;
                    wm_q     <= lane_mask(lsu.funct3, off_d);
                end
            end
            if ((state_q == ACCESS) && !st_q)
                rdata_q <= load_data;
        end
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Bench for lsu_ctrl: directed vector table, hand-written multi-cycle
// sequences, and random traffic against a byte-level reference memory.
module tb_lsu_ctrl;
    import lsu_pkg::*;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic mem_clr = 1'b1;
    int   nchk = 0;
    int   nerr = 0;

    always #5 clk = ~clk;

    lsu_ctrl_if bus();
    lsu_ctrl_if bus0();

    lsu_ctrl #(.MISALIGN_TRAP(1'b1)) u_dut (
        .clk     (clk),
        .reset_n (reset_n),
        .lsu     (bus.slave)
    );

    lsu_ctrl #(.MISALIGN_TRAP(1'b0)) u_dut0 (
        .clk     (clk),
        .reset_n (reset_n),
        .lsu     (bus0.slave)
    );

    // Word memory seen by the DUTs; lanes filled from the low end of mem_wd.
    logic [31:0] mem_w [0:63];
    logic [7:0]  shadow [0:255];

    assign bus.mem_rd  = mem_w[bus.mem_a[7:2]];
    assign bus0.mem_rd = mem_w[bus0.mem_a[7:2]];

    always @(posedge clk) begin : mem_write
        int j;
        if (mem_clr) begin
            for (int i = 0; i < 64; i++) mem_w[i] <= '0;
        end else if (bus.mem_we === 1'b1) begin
            j = 0;
            for (int l = 0; l < 4; l++) begin
                if (bus.mem_wm[l]) begin
                    mem_w[bus.mem_a[7:2]][8*l +: 8] <= bus.mem_wd[8*j +: 8];
                    j++;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic int acc_size(input logic [2:0] f3);
        if (f3[1:0] == 2'd0) return 1;
        if (f3[1:0] == 2'd1) return 2;
        return 4;
    endfunction

    // Reference: byte-addressed memory, size/alignment arithmetic.
    function automatic void model(input logic st, input logic [2:0] f3, input logic [31:0] a,
                                  output logic e, output logic [31:0] rd, output logic [3:0] wm);
        int size;
        bit legal;
        longint v;
        size = acc_size(f3);
        if (st) legal = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2);
        else    legal = (f3 != 3'd3) && (f3 != 3'd6) && (f3 != 3'd7);
        e  = !legal || ((a % size) != 0);
        rd = '0;
        wm = '0;
        if (!e) begin
            for (int i = 0; i < size; i++) wm[int'(a[1:0]) + i] = 1'b1;
            if (!st) begin
                v = 0;
                for (int i = 0; i < size; i++)
                    v = v + (longint'(shadow[int'(a[7:0]) + i]) << (8 * i));
                if (!f3[2] && size < 4 && shadow[int'(a[7:0]) + size - 1][7])
                    v = v - (longint'(1) << (8 * size));
                rd = v[31:0];
            end
        end
    endfunction

    task automatic shadow_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
        for (int i = 0; i < acc_size(f3); i++)
            shadow[int'(a[7:0]) + i] = 8'((wd >> (8 * i)) & 32'hFF);
    endtask

    task automatic do_req(input logic st, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, output logic e, output logic [31:0] rd,
                          output logic [3:0] wm, output logic [31:0] ma, output logic [31:0] mwd,
                          output int we_cnt, output int lat);
        int t;
        @(negedge clk);
        t = 0;
        while (!bus.ready && t < 10) begin
            @(negedge clk);
            t++;
        end
        bus.req      = 1'b1;
        bus.is_store = st;
        bus.funct3   = f3;
        bus.addr     = a;
        bus.wdata    = wd;
        @(posedge clk);
        #1;
        bus.req      = 1'b0;
        bus.is_store = 1'($urandom);
        bus.funct3   = 3'($urandom);
        bus.addr     = $urandom;
        bus.wdata    = $urandom;
        e = 1'bx; rd = 'x; wm = '0; ma = '0; mwd = '0; we_cnt = 0; lat = 0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (bus.mem_wm != 4'b0) begin
                wm = bus.mem_wm;
                ma = bus.mem_a;
            end
            if (bus.mem_we) begin
                we_cnt++;
                mwd = bus.mem_wd;
            end
            if (bus.rvalid) begin
                lat = k;
                e   = bus.err;
                rd  = bus.rdata;
                break;
            end
        end
    endtask

    task automatic run_check(input string name, input logic st, input logic [2:0] f3,
                             input logic [31:0] a, input logic [31:0] wd, input logic exp_e,
                             input logic [31:0] exp_rd, input logic [3:0] exp_wm);
        logic e; logic [31:0] rd; logic [3:0] wm; logic [31:0] ma, mwd; int wc, lat;
        do_req(st, f3, a, wd, e, rd, wm, ma, mwd, wc, lat);
        chk($sformatf("%s.lat", name), lat, exp_e ? 32'd1 : 32'd2);
        chk($sformatf("%s.err", name), {31'b0, e}, {31'b0, exp_e});
        chk($sformatf("%s.rdata", name), rd, exp_rd);
        chk($sformatf("%s.we_cnt", name), wc, (st && !exp_e) ? 32'd1 : 32'd0);
        chk($sformatf("%s.wm", name), {28'b0, wm}, {28'b0, exp_wm});
        if (!exp_e) chk($sformatf("%s.mem_a", name), ma, {a[31:2], 2'b00});
        if (st && !exp_e) chk($sformatf("%s.mem_wd", name), mwd, wd);
    endtask

    task automatic do_req0(input logic [2:0] f3, input logic [31:0] a,
                           output logic e, output logic [31:0] rd, output int lat);
        @(negedge clk);
        bus0.req      = 1'b1;
        bus0.is_store = 1'b0;
        bus0.funct3   = f3;
        bus0.addr     = a;
        @(posedge clk);
        #1;
        bus0.req = 1'b0;
        e = 1'bx; rd = 'x; lat = 0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (bus0.rvalid) begin
                lat = k;
                e   = bus0.err;
                rd  = bus0.rdata;
                break;
            end
        end
    endtask

    typedef struct {
        string       name;
        logic        st;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] wd;
        logic        exp_e;
        logic [31:0] exp_rd;
        logic [3:0]  exp_wm;
    } vec_t;

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin : main
        vec_t vecs[$];
        logic e; logic [31:0] rd; logic [3:0] wm; int lat;
        logic [11:0] rdy_mask, rv_mask;
        int rv_cnt;

        bus.req = 1'b0; bus.is_store = 1'b0; bus.funct3 = '0; bus.addr = '0; bus.wdata = '0;
        bus0.req = 1'b0; bus0.is_store = 1'b0; bus0.funct3 = '0; bus0.addr = '0; bus0.wdata = '0;
        for (int i = 0; i < 256; i++) shadow[i] = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst.ready",  {31'b0, bus.ready},  32'd1);
        chk("rst.rvalid", {31'b0, bus.rvalid}, 32'd0);
        chk("rst.err",    {31'b0, bus.err},    32'd0);
        chk("rst.rdata",  bus.rdata,           32'd0);
        chk("rst.mem_we", {31'b0, bus.mem_we}, 32'd0);
        chk("rst.mem_wm", {28'b0, bus.mem_wm}, 32'd0);
        chk("rst.mem_a",  bus.mem_a,           32'd0);
        chk("rst.mem_wd", bus.mem_wd,          32'd0);
        reset_n = 1'b1;
        mem_clr = 1'b0;

        vecs.push_back('{"sw10",   1'b1, F3_W,   32'h10, 32'h0,        1'b0, 32'h0,        4'b1111});
        vecs.push_back('{"sw20",   1'b1, F3_W,   32'h20, 32'h0,        1'b0, 32'h0,        4'b1111});
        vecs.push_back('{"sw40",   1'b1, F3_W,   32'h40, 32'h80F07F81, 1'b0, 32'h0,        4'b1111});
        vecs.push_back('{"sb13",   1'b1, F3_B,   32'h13, 32'h000000AB, 1'b0, 32'h0,        4'b1000});
        vecs.push_back('{"sh22",   1'b1, F3_H,   32'h22, 32'h00001234, 1'b0, 32'h0,        4'b1100});
        vecs.push_back('{"lw20",   1'b0, F3_W,   32'h20, 32'h0,        1'b0, 32'h12340000, 4'b1111});
        vecs.push_back('{"lw10",   1'b0, F3_W,   32'h10, 32'h0,        1'b0, 32'hAB000000, 4'b1111});
        vecs.push_back('{"lb40",   1'b0, F3_B,   32'h40, 32'h0,        1'b0, 32'hFFFFFF81, 4'b0001});
        vecs.push_back('{"lbu43",  1'b0, F3_BU,  32'h43, 32'h0,        1'b0, 32'h00000080, 4'b1000});
        vecs.push_back('{"lh42",   1'b0, F3_H,   32'h42, 32'h0,        1'b0, 32'hFFFF80F0, 4'b1100});
        vecs.push_back('{"lhu40",  1'b0, F3_HU,  32'h40, 32'h0,        1'b0, 32'h00007F81, 4'b0011});
        vecs.push_back('{"lw41",   1'b0, F3_W,   32'h41, 32'h0,        1'b1, 32'h0,        4'b0000});
        vecs.push_back('{"sh45",   1'b1, F3_H,   32'h45, 32'hFFFF,     1'b1, 32'h0,        4'b0000});
        vecs.push_back('{"ld_f3_3",1'b0, 3'b011, 32'h40, 32'h0,        1'b1, 32'h0,        4'b0000});
        vecs.push_back('{"st_f3_4",1'b1, F3_BU,  32'h40, 32'h55,       1'b1, 32'h0,        4'b0000});
        vecs.push_back('{"lw40",   1'b0, F3_W,   32'h40, 32'h0,        1'b0, 32'h80F07F81, 4'b1111});

        foreach (vecs[i]) begin
            run_check(vecs[i].name, vecs[i].st, vecs[i].f3, vecs[i].a, vecs[i].wd,
                      vecs[i].exp_e, vecs[i].exp_rd, vecs[i].exp_wm);
            if (vecs[i].st && !vecs[i].exp_e) shadow_store(vecs[i].f3, vecs[i].a, vecs[i].wd);
        end

        // Non-trapping instance: offsets are aligned down instead of faulting.
        do_req0(F3_W, 32'h41, e, rd, lat);
        chk("nt_lw41.lat", lat, 32'd2);
        chk("nt_lw41.err", {31'b0, e}, 32'd0);
        chk("nt_lw41.rdata", rd, 32'h80F07F81);
        do_req0(F3_H, 32'h43, e, rd, lat);
        chk("nt_lh43.err", {31'b0, e}, 32'd0);
        chk("nt_lh43.rdata", rd, 32'hFFFF80F0);

        // Back-to-back: req held high.
        @(negedge clk);
        for (int t = 0; t < 10 && !bus.ready; t++) @(negedge clk);
        bus.req = 1'b1; bus.is_store = 1'b0; bus.funct3 = F3_W; bus.addr = 32'h40;
        for (int c = 0; c < 12; c++) begin
            rdy_mask[c] = bus.ready;
            rv_mask[c]  = bus.rvalid;
            @(negedge clk);
        end
        bus.req = 1'b0;
        chk("b2b.ready_pattern",  {20'b0, rdy_mask}, 32'h249);
        chk("b2b.rvalid_pattern", {20'b0, rv_mask},  32'h924);

        // Reset during a store's ACCESS cycle.
        @(negedge clk);
        bus.req = 1'b1; bus.is_store = 1'b1; bus.funct3 = F3_W; bus.addr = 32'h60; bus.wdata = 32'hDEADBEEF;
        @(posedge clk);
        #1 bus.req = 1'b0;
        @(negedge clk);
        chk("rstmid.we_before", {31'b0, bus.mem_we}, 32'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("rstmid.we_after",  {31'b0, bus.mem_we}, 32'd0);
        chk("rstmid.wm_after",  {28'b0, bus.mem_wm}, 32'd0);
        chk("rstmid.ready",     {31'b0, bus.ready},  32'd1);
        @(negedge clk);
        reset_n = 1'b1;
        rv_cnt = 0;
        repeat (5) begin
            @(negedge clk);
            if (bus.rvalid) rv_cnt++;
        end
        chk("rstmid.no_rvalid", rv_cnt, 32'd0);
        model(1'b0, F3_W, 32'h60, e, rd, wm);
        run_check("rstmid.lw60", 1'b0, F3_W, 32'h60, 32'h0, e, rd, wm);

        // Random traffic against the reference memory.
        for (int n = 0; n < 200; n++) begin
            logic st; logic [2:0] f3; logic [31:0] a, wd;
            st = 1'($urandom);
            f3 = 3'($urandom);
            a  = 32'($urandom_range(255, 0));
            wd = $urandom;
            model(st, f3, a, e, rd, wm);
            run_check($sformatf("rnd%0d", n), st, f3, a, wd, e, rd, wm);
            if (st && !e) shadow_store(f3, a, wd);
        end

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
